// File: rtl/word_packer_pkg.sv
// -----------------------------------------------------------------------------
// word_packer_pkg
//   Shared helpers for word_packer.
//   slot_offset : bit offset of word k inside an output word, honouring the
//                 compile-time endianness.
//   clamp_words : maps a requested word count onto 1..max_words; 0 and
//                 out-of-range requests select max_words.
// -----------------------------------------------------------------------------
package word_packer_pkg;

   function automatic int slot_offset(input int k, input int max_words,
                                      input int in_width, input bit big_endian);
      if (big_endian)
         return (max_words - 1 - k) * in_width;
      else
         return k * in_width;
   endfunction

   function automatic int clamp_words(input int n, input int max_words);
      if (n == 0 || n > max_words)
         return max_words;
      else
         return n;
   endfunction

endpackage

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
//   Packs a stream of IN_WIDTH-bit words into OUT_WIDTH-bit output words with
//   a runtime word count, early close via a last flag and valid/ready
//   handshakes on both sides.
//
// Ports
//   clk_i        in   clock, rising edge
//   reset_i      in   asynchronous active-high reset
//   num_words_i  in   words per output word (0 or >MAX_WORDS => MAX_WORDS),
//                     sampled when the first word of an output word is taken
//   in_data_i    in   input word
//   in_valid_i   in   input word present
//   in_last_i    in   accepted word closes the current output word
//   in_ready_o   out  block accepts in_data_i this cycle
//   out_data_o   out  packed output word, unfilled slots zero
//   out_words_o  out  number of valid words in out_data_o
//   out_valid_o  out  output word present, held until accepted
//   out_ready_i  in   consumer accepts the output this cycle
// -----------------------------------------------------------------------------
module word_packer
   import word_packer_pkg::*;
#(
   parameter int IN_WIDTH   = 8,
   parameter int MAX_WORDS  = 4,
   parameter int BIG_ENDIAN = 0,
   localparam int OUT_WIDTH = IN_WIDTH * MAX_WORDS,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [CNT_W-1:0]     num_words_i,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic                 in_valid_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0]     out_words_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   localparam bit BE = (BIG_ENDIAN != 0);

   logic [OUT_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     tgt;

   logic [CNT_W-1:0]     num_clamped;
   logic [CNT_W-1:0]     eff_tgt;
   logic                 completing;
   logic                 in_beat;
   logic                 out_beat;
   logic [OUT_WIDTH-1:0] merged;

   // Completion and ready depend only on registered state and control inputs,
   // never on in_data_i, so no data-to-ready combinational path exists.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through this block can infer a latch.
      num_clamped = CNT_W'(clamp_words(int'(num_words_i), MAX_WORDS));
      eff_tgt     = tgt;
      completing  = 1'b0;
      merged      = '0;

      // At the first word of an output word the fresh count applies.
      if (cnt == '0)
         eff_tgt = num_clamped;

      completing = in_valid_i && (in_last_i || (cnt == eff_tgt - CNT_W'(1)));

      // Slots not yet written are zero, so OR-ing the shifted word suffices.
      merged = ((cnt == '0) ? '0 : acc)
             | (OUT_WIDTH'(in_data_i) << slot_offset(int'(cnt), MAX_WORDS, IN_WIDTH, BE));
   end

   // Only a completing word has to wait for the output register to drain.
   assign in_ready_o = !out_valid_o || out_ready_i || !completing;
   assign in_beat    = in_valid_i && in_ready_o;
   assign out_beat   = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         acc         <= '0;
         cnt         <= '0;
         tgt         <= CNT_W'(MAX_WORDS);
         out_data_o  <= '0;
         out_words_o <= '0;
         out_valid_o <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // sees the pre-edge values and later writes override earlier ones.
         if (out_beat)
            out_valid_o <= 1'b0;

         if (in_beat) begin
            if (cnt == '0)
               tgt <= num_clamped;

            if (completing) begin
               out_data_o  <= merged;
               out_words_o <= cnt + CNT_W'(1);
               out_valid_o <= 1'b1;
               acc         <= '0;
               cnt         <= '0;
            end else begin
               acc <= merged;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Parametrised successor to the serial word concatenator.
- Packs a stream of IN_WIDTH-bit words into OUT_WIDTH-bit output words.
- Adds a runtime-selectable word count, compile-time endianness, early close of a partial word via a last flag, and valid/ready backpressure on both sides.
- Sits between narrow byte/word producers (UART, SPI, camera pixel streams) and wider consumers (FIFOs, memory writers).

Parameters:
- IN_WIDTH, 8, width of each input word.
- MAX_WORDS, 4, maximum words per output word (>=1).
- BIG_ENDIAN, 0, 0: first word in the least-significant slot; 1: first word in the most-significant slot.
- OUT_WIDTH, IN_WIDTH*MAX_WORDS, derived localparam.
- CNT_W, $clog2(MAX_WORDS+1), derived localparam, width of word counts.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- num_words_i  in  CNT_W  words per output word. 0 or >MAX_WORDS is treated as MAX_WORDS. Sampled when the first word of an output word is accepted.
- in_data_i  in  IN_WIDTH  input word.
- in_valid_i  in  1  input word present.
- in_last_i  in  1  accepted word closes the current output word early.
- in_ready_o  out  1  block can accept in_data_i this cycle.
- out_data_o  out  OUT_WIDTH  packed output word; unfilled slots are zero.
- out_words_o  out  CNT_W  number of valid words in out_data_o (1..MAX_WORDS).
- out_valid_o  out  1  output word present; held until accepted.
- out_ready_i  in  1  consumer accepts the output this cycle.

Behaviour:
- Handshakes:
  - Input beat = in_valid_i && in_ready_o.
  - Output beat = out_valid_o && out_ready_i.
  - While out_valid_o is high, out_data_o and out_words_o hold stable.
- Internal state:
  - accumulation register acc (OUT_WIDTH)
  - count cnt (CNT_W, 0..MAX_WORDS-1)
  - latched target tgt (CNT_W)
  - output register (out_data_o, out_words_o, out_valid_o)
- Slot placement:
  - Word k (0-based within the output word) goes to bit offset k*IN_WIDTH when BIG_ENDIAN=0.
  - It goes to offset (MAX_WORDS-1-k)*IN_WIDTH when BIG_ENDIAN=1.
  - Example, MAX_WORDS=4, words f0 0f ba 11: BIG_ENDIAN=1 gives 32'hf00fba11; BIG_ENDIAN=0 gives 32'h11ba0ff0.
- Start of an output word: on an input beat with cnt==0, tgt latches the clamped num_words_i and acc is cleared except for the slot being written.
- Completion: an input beat completes the output word when cnt==tgt-1 (using the fresh tgt if cnt==0) or in_last_i=1.
- On a completing beat:
  - Output register loads acc merged with the new word; out_words_o = cnt+1; out_valid_o=1 next cycle.
  - acc is cleared and cnt returns to 0.
- Non-completing beat: word written into its slot; cnt increments.
- Ready rule: in_ready_o = !out_valid_o || out_ready_i || !completing.
  - Non-completing words keep accumulating while the output is stalled.
  - Only the completing word stalls.
  - Combinational from registered state, out_ready_i, num_words_i, in_last_i and in_valid_i; no combinational path from in_data_i.
- Timing:
  - Latency: completing word accepted in cycle N gives out_valid_o high in cycle N+1.
  - Throughput: one input word per cycle. Output beat and completing input beat in the same cycle are legal, giving back-to-back output words.
- num_words_i=1: every input beat is a completing beat; out_words_o=1.
- num_words_i changes mid-word: ignored until the next word start.
- in_last_i on the first word of an output word: out_words_o=1.
- Reset (async assert, synchronous deassert via the reset tree):
  - out_valid_o=0, out_data_o=0, out_words_o=0, cnt=0, tgt=MAX_WORDS, acc=0.
  - A partial word is discarded on reset mid-operation.
- X-safety: no X driven on outputs after reset.

Decomposition:
- Package word_packer_pkg:
  - function slot_offset(k, max_words, in_width, big_endian).
  - function clamp_words(n, max_words).
- No sub-module; a single always_ff plus small combinational ready/complete logic (~150–200 RTL lines).

Test Plan:
- Scenario 1, full words: IN_WIDTH=8, MAX_WORDS=4, BIG_ENDIAN=1, num_words_i=4, out_ready_i=1, feed f0,0f,ba,11 on consecutive cycles.
  - Required: out_data_o=32'hf00fba11, out_words_o=4, out_valid_o high exactly one cycle, one cycle after the 4th beat.
  - Repeat with BIG_ENDIAN=0 -> 32'h11ba0ff0.
- Scenario 2, early close: num_words_i=4, BIG_ENDIAN=0, feed aa then bb with in_last_i=1.
  - Required: out_data_o=32'h0000bbaa, out_words_o=2.
  - Following word starts fresh at slot 0.
- Scenario 3, runtime count: num_words_i=2 for the first output word, changed to 3 after its first beat; feed 01..05.
  - Required: outputs 16'h0201 (words=2) then 0x050403 (words=3, if num_words_i=3 at that start).
- Scenario 4, backpressure: out_ready_i=0 with a pending output, stream 4 more words.
  - Required: first 3 accepted, 4th held with in_ready_o=0.
  - Raise out_ready_i: both output words delivered in order, no loss or duplication.
- Scenario 5, reset mid-word: assert reset_i asynchronously between clock edges after 2 of 4 words.
  - Required: out_valid_o=0 and out_data_o=0 immediately.
  - After release, the next 4 words produce one correct output word.
- Scenario 6, random: constrained-random valid/ready/last/num_words for 10k cycles against a scoreboard model.
  - Required: every input word appears in exactly one output slot, in order.
